// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS-style datapath: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Strobes are decoded from the current state and the stable IR opcode; ext_sel is latched in DECODE.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src_imm,
  output logic       ext_sel,
  output logic       illegal,
  output logic [2:0] state
);

  // Extension choice only matters when the immediate is narrower than the datapath.
  localparam int IMM_WIDTH  = DATA_WIDTH / 2;
  localparam bit EXT_ACTIVE = (IMM_WIDTH < DATA_WIDTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   ext_sel_q, ext_sel_d;

  logic is_rtype, is_imm, is_zext, is_lw, is_sw, is_beq, is_legal;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
    is_imm   = (opcode == OP_ADDI) || is_zext;
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_legal = is_rtype || is_imm || is_lw || is_sw || is_beq;
  end

  logic mem_read_c, mem_write_c, ir_write_c, pc_write_c;
  logic reg_write_c, alu_src_imm_c, illegal_c;

  always_comb begin
    state_d       = state_q;
    ext_sel_d     = ext_sel_q;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    alu_src_imm_c = 1'b0;
    illegal_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ext_sel_d = EXT_ACTIVE && is_zext;
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_imm_c = is_imm || is_lw || is_sw;
        if (is_beq) begin
          pc_write_c = alu_zero;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_rtype || is_imm) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ext_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_sel_q <= ext_sel_d;
    end
  end

  // Strobes are gated by rst so an in-flight access drops the moment reset rises.
  assign mem_read    = mem_read_c    & ~rst;
  assign mem_write   = mem_write_c   & ~rst;
  assign ir_write    = ir_write_c    & ~rst;
  assign pc_write    = pc_write_c    & ~rst;
  assign reg_write   = reg_write_c   & ~rst;
  assign alu_src_imm = alu_src_imm_c & ~rst;
  assign illegal     = illegal_c     & ~rst;
  assign ext_sel     = ext_sel_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into an expected
// per-cycle trace from the instruction-level rules, then played and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       alu_zero, mem_ready;
  logic       mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_imm, ext_sel, illegal;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;
  logic model_ext = 1'b0;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_imm(alu_src_imm), .ext_sel(ext_sel), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // Observed vector: {state, ext_sel, mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_imm, illegal}
  function automatic logic [15:0] observed();
    return {5'd0, state, ext_sel, mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_imm, illegal};
  endfunction

  function automatic logic [15:0] vec(input int st, input logic ex, input logic [6:0] strobes);
    logic [2:0] s3;
    s3 = 3'(st);
    return {5'd0, s3, ex, strobes};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Strobe bit order: mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_imm, illegal
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic az);
    logic [15:0] exp_q[$];
    logic        mr_q[$];
    logic        legal, lw, sw, beq, rtype, imm, zext;
    rtype = (op == 6'b000000);
    zext  = (op == 6'b001100) || (op == 6'b001101);
    imm   = (op == 6'b001000) || zext;
    lw    = (op == 6'b100011);
    sw    = (op == 6'b101011);
    beq   = (op == 6'b000100);
    legal = rtype || imm || lw || sw || beq;

    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(vec(0, model_ext, 7'b1000000)); mr_q.push_back(1'b0);
    end
    exp_q.push_back(vec(0, model_ext, 7'b1011000)); mr_q.push_back(1'b1);
    exp_q.push_back(vec(1, model_ext, legal ? 7'b0000000 : 7'b0000001));
    mr_q.push_back(1'($urandom_range(0, 1)));
    model_ext = zext;
    if (legal) begin
      exp_q.push_back(vec(2, model_ext, {3'b000, beq && az, 1'b0, !(rtype || beq), 1'b0}));
      mr_q.push_back(1'($urandom_range(0, 1)));
      if (lw || sw) begin
        for (int i = 0; i <= mw; i++) begin
          exp_q.push_back(vec(3, model_ext, lw ? 7'b1000000 : 7'b0100000));
          mr_q.push_back(i == mw);
        end
      end
      if (!sw && !beq) begin
        exp_q.push_back(vec(4, model_ext, 7'b0000100));
        mr_q.push_back(1'($urandom_range(0, 1)));
      end
    end

    for (int k = 0; k < exp_q.size(); k++) begin
      opcode    = op;
      mem_ready = mr_q[k];
      alu_zero  = (exp_q[k][10:8] == 3'd2) ? az : 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("op%b_cyc%0d", op, k), observed(), exp_q[k]);
      @(posedge clk); #1;
    end
    $display("instr op=%b fw=%0d mw=%0d az=%0b cycles=%0d", op, fw, mw, az, exp_q.size());
  endtask

  // SW stalled in MEM, reset pulsed mid-cycle: request must drop at once, then FETCH restarts.
  task automatic reset_abort();
    opcode = 6'b101011; alu_zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("sw_mem_stall", observed(), vec(3, 1'b0, 7'b0100000));
    #2 rst = 1'b1;
    #1 check("rst_async_drop", observed(), vec(0, 1'b0, 7'b0000000));
    @(posedge clk); @(negedge clk);
    check("rst_held", observed(), vec(0, 1'b0, 7'b0000000));
    #2 rst = 1'b0;
    #1 check("rst_release_fetch", observed(), vec(0, 1'b0, 7'b1000000));
    model_ext = 1'b0;
    @(posedge clk); #1;
    $display("instr reset_abort during SW MEM stall");
  endtask

  logic [5:0] legal_ops [7] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                6'b100011, 6'b101011, 6'b000100};

  initial begin
    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_state", observed(), vec(0, 1'b0, 7'b0000000));
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b001000, 0, 0, 1'b0);   // ADDI
    run_instr(6'b001101, 0, 0, 1'b0);   // ORI
    run_instr(6'b001000, 0, 0, 1'b0);   // ADDI clears ext_sel
    run_instr(6'b100011, 2, 3, 1'b0);   // LW with waits
    run_instr(6'b000100, 0, 0, 1'b1);   // BEQ taken
    run_instr(6'b000100, 1, 0, 1'b0);   // BEQ not taken
    run_instr(6'b111111, 0, 0, 1'b0);   // illegal
    run_instr(6'b001100, 1, 0, 1'b0);   // ANDI
    run_instr(6'b101011, 0, 2, 1'b0);   // SW
    run_instr(6'b000000, 0, 0, 1'b1);   // RTYPE
    reset_abort();

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 6)] : 6'($urandom);
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
